// File: rtl/cpu_call_stack.sv
// Return-address stack for PC control: services CALL > RET > JMP,
// driving a same-cycle PC load and tracking sticky over/underflow.
module cpu_call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           PC_IN,
  input  logic [WIDTH-1:0]           TARGET,
  input  logic                       JMP,
  input  logic                       CALL,
  input  logic                       RET,
  output logic                       LD,
  output logic [WIDTH-1:0]           ADDR,
  output logic [$clog2(DEPTH):0]     CNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVF,
  output logic                       UNF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt = '0;
  logic             r_ovf = 1'b0;
  logic             r_unf = 1'b0;

  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_push_idx;
  logic [AW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_ret_addr;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_ld;
  logic [WIDTH-1:0] w_addr;

  assign w_full     = (r_cnt == CNT_FULL);
  assign w_empty    = (r_cnt == '0);
  // At CNT==DEPTH the low bits wrap to 0, so the top index still lands on DEPTH-1.
  assign w_push_idx = r_cnt[AW-1:0];
  assign w_top_idx  = r_cnt[AW-1:0] - AW'(1);
  assign w_ret_addr = PC_IN + WIDTH'(1);

  always_comb begin
    w_ld      = 1'b0;
    w_addr    = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (!RST) begin
      priority case (1'b1)
        CALL: begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_ld   = 1'b1;
            w_addr = TARGET;
            w_push = 1'b1;
          end
        end
        RET: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_ld   = 1'b1;
            w_addr = r_mem[w_top_idx];
            w_pop  = 1'b1;
          end
        end
        JMP: begin
          w_ld   = 1'b1;
          w_addr = TARGET;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[w_push_idx] <= w_ret_addr;
        r_cnt             <= r_cnt + CW'(1);
      end else if (w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  assign LD    = w_ld;
  assign ADDR  = w_addr;
  assign CNT   = r_cnt;
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;

endmodule

// File: tb/tb_cpu_call_stack.sv
// Directed vector bench for cpu_call_stack (WIDTH=8, DEPTH=4).
module tb_cpu_call_stack;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] PC_IN, TARGET;
  logic       JMP, CALL, RET;
  logic       LD;
  logic [7:0] ADDR;
  logic [2:0] CNT;
  logic       FULL, EMPTY, OVF, UNF;

  cpu_call_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .PC_IN(PC_IN), .TARGET(TARGET),
    .JMP(JMP), .CALL(CALL), .RET(RET),
    .LD(LD), .ADDR(ADDR), .CNT(CNT),
    .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, call, ret, jmp;
    logic [7:0] pc, tgt;
    logic       ld;
    logic [7:0] addr;
    logic [2:0] cnt;
    logic       full, empty, ovf, unf;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(
    logic r, logic c, logic t, logic j,
    logic [7:0] pc, logic [7:0] tgt,
    logic ld, logic [7:0] addr, logic [2:0] cnt,
    logic ovf, logic unf);
    vec_t v;
    v.rst = r; v.call = c; v.ret = t; v.jmp = j;
    v.pc = pc; v.tgt = tgt;
    v.ld = ld; v.addr = addr; v.cnt = cnt;
    v.full = (cnt == 3'd4); v.empty = (cnt == 3'd0);
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s vec %0d: got 0x%0h, want 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Inputs set just after an edge; comb outputs checked before the
  // next edge, registered state checked just after it.
  task automatic apply(vec_t v, int idx);
    RST = v.rst; CALL = v.call; RET = v.ret; JMP = v.jmp;
    PC_IN = v.pc; TARGET = v.tgt;
    #2;
    nvec++;
    chk("LD", idx, 32'(LD), 32'(v.ld));
    chk("ADDR", idx, 32'(ADDR), 32'(v.addr));
    @(posedge CLK);
    #1;
    chk("CNT", idx, 32'(CNT), 32'(v.cnt));
    chk("FULL", idx, 32'(FULL), 32'(v.full));
    chk("EMPTY", idx, 32'(EMPTY), 32'(v.empty));
    chk("OVF", idx, 32'(OVF), 32'(v.ovf));
    chk("UNF", idx, 32'(UNF), 32'(v.unf));
  endtask

  initial begin
    RST = 1'b0; CALL = 1'b0; RET = 1'b0; JMP = 1'b0;
    PC_IN = '0; TARGET = '0;

    // power-up state before any reset
    #1;
    nvec++;
    chk("PWRUP_CNT", -1, 32'(CNT), 32'd0);
    chk("PWRUP_EMPTY", -1, 32'(EMPTY), 32'd1);
    chk("PWRUP_LD", -1, 32'(LD), 32'd0);

    //             rst c r j  pc     tgt    ld addr   cnt  ovf unf
    vecs.push_back(mk(1,0,0,0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, 0));
    vecs.push_back(mk(0,0,0,1, 8'h05, 8'h40, 1, 8'h40, 3'd0, 0, 0));
    vecs.push_back(mk(0,1,0,0, 8'h10, 8'h80, 1, 8'h80, 3'd1, 0, 0));
    vecs.push_back(mk(0,0,1,0, 8'h80, 8'h00, 1, 8'h11, 3'd0, 0, 0));
    vecs.push_back(mk(0,0,0,0, 8'h33, 8'h44, 0, 8'h00, 3'd0, 0, 0));
    vecs.push_back(mk(0,1,0,0, 8'h01, 8'h30, 1, 8'h30, 3'd1, 0, 0));
    vecs.push_back(mk(0,1,0,0, 8'h02, 8'h31, 1, 8'h31, 3'd2, 0, 0));
    vecs.push_back(mk(0,1,0,0, 8'h03, 8'h32, 1, 8'h32, 3'd3, 0, 0));
    vecs.push_back(mk(0,1,0,0, 8'h04, 8'h33, 1, 8'h33, 3'd4, 0, 0));
    vecs.push_back(mk(0,1,0,0, 8'h50, 8'h60, 0, 8'h00, 3'd4, 1, 0));
    vecs.push_back(mk(0,0,0,1, 8'h51, 8'h22, 1, 8'h22, 3'd4, 1, 0));
    vecs.push_back(mk(0,0,1,0, 8'h52, 8'h00, 1, 8'h05, 3'd3, 1, 0));
    vecs.push_back(mk(0,0,1,0, 8'h53, 8'h00, 1, 8'h04, 3'd2, 1, 0));
    vecs.push_back(mk(0,0,1,0, 8'h54, 8'h00, 1, 8'h03, 3'd1, 1, 0));
    vecs.push_back(mk(0,0,1,0, 8'h55, 8'h00, 1, 8'h02, 3'd0, 1, 0));
    vecs.push_back(mk(0,0,1,0, 8'h56, 8'h00, 0, 8'h00, 3'd0, 1, 1));
    vecs.push_back(mk(0,1,1,1, 8'hFF, 8'h20, 1, 8'h20, 3'd1, 1, 1));
    vecs.push_back(mk(0,0,1,0, 8'h20, 8'h00, 1, 8'h00, 3'd0, 1, 1));
    vecs.push_back(mk(0,0,1,1, 8'h21, 8'h44, 0, 8'h00, 3'd0, 1, 1));
    vecs.push_back(mk(1,0,0,0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, 0));

    @(posedge CLK);
    #1;
    foreach (vecs[i]) apply(vecs[i], i);

    // back-to-back CALL/CALL/RET/RET with distinct return addresses
    apply(mk(0,1,0,0, 8'hA0, 8'h10, 1, 8'h10, 3'd1, 0, 0), 100);
    apply(mk(0,1,0,0, 8'h10, 8'h70, 1, 8'h70, 3'd2, 0, 0), 101);
    apply(mk(0,0,1,0, 8'h70, 8'h00, 1, 8'h11, 3'd1, 0, 0), 102);
    apply(mk(0,1,0,0, 8'h11, 8'h90, 1, 8'h90, 3'd2, 0, 0), 103);
    apply(mk(0,0,1,0, 8'h90, 8'h00, 1, 8'h12, 3'd1, 0, 0), 104);
    apply(mk(0,0,1,0, 8'h12, 8'h00, 1, 8'hA1, 3'd0, 0, 0), 105);

    // fill, overflow, pop one, then reset while CALL is asserted at CNT=3
    apply(mk(0,1,0,0, 8'h01, 8'hC0, 1, 8'hC0, 3'd1, 0, 0), 200);
    apply(mk(0,1,0,0, 8'h02, 8'hC1, 1, 8'hC1, 3'd2, 0, 0), 201);
    apply(mk(0,1,0,0, 8'h03, 8'hC2, 1, 8'hC2, 3'd3, 0, 0), 202);
    apply(mk(0,1,0,0, 8'h04, 8'hC3, 1, 8'hC3, 3'd4, 0, 0), 203);
    apply(mk(0,1,1,0, 8'h05, 8'hC4, 0, 8'h00, 3'd4, 1, 0), 204);
    apply(mk(0,0,1,0, 8'h06, 8'h00, 1, 8'h05, 3'd3, 1, 0), 205);
    apply(mk(1,1,0,0, 8'h07, 8'hC5, 0, 8'h00, 3'd0, 0, 0), 206);
    apply(mk(0,0,1,0, 8'h08, 8'h00, 0, 8'h00, 3'd0, 0, 1), 207);
    apply(mk(1,0,1,1, 8'h09, 8'h55, 0, 8'h00, 3'd0, 0, 0), 208);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
